// File: rtl/down_timer_pkg.sv
// Shared definitions for the down-counting timer: state encoding and default width.
// The default width matches the free-running up-counter it sits beside.
package down_timer_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/down_timer.sv
// Loadable down-counting timer with a one-cycle done pulse on expiry and optional
// auto-reload, so it can serve as a periodic tick source.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    input  logic             stop,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done
);

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt_n;
    logic [WIDTH-1:0] reload, reload_n;
    logic             done_n;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            reload <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            reload <= reload_n;
            done   <= done_n;
        end
    end

    // Priority: load, then stop, then an enabled decrement while running.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        reload_n = reload;
        done_n   = 1'b0;
        if (load) begin
            reload_n = load_val;
            cnt_n    = load_val;
            if (load_val != '0) begin
                state_n = ST_RUN;
            end else begin
                state_n = ST_IDLE;
                done_n  = 1'b1;
            end
        end else if (stop) begin
            state_n = ST_IDLE;
        end else if (state == ST_RUN && en) begin
            // RUN always holds cnt >= 1, so reaching 1 is the expiry edge.
            if (cnt == WIDTH'(1)) begin
                done_n = 1'b1;
                if (auto_reload) begin
                    cnt_n = reload;
                end else begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end
            end else begin
                cnt_n = cnt - WIDTH'(1);
            end
        end
    end

    assign busy = (state == ST_RUN);

endmodule
